mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
// - Shares the single tagged memory port between the icache (instruction fetch) and the dcache (loads/stores).
// - Grant is combinational, so an accept response reaches the winning cache in the same cycle it issues its command.
// - A 16-entry tag->owner table routes each returned data tag to the cache that issued it.
// - Sits between the icache/dcache and the mem model; neither cache is aware of the other.
// PARAMETERS
// - NUM_TAGS  16  entries in the owner table; equals the tag space (tag 0 = none)
// - MAX_WAIT   4  consecutive icache denials before the icache is forced ahead (MEM_ARB_FAIR_EN only)
// PORTS
// - clock                in   1   system clock; all state updates on posedge
// - reset                in   1   synchronous, active-low: reset==0 at posedge clears all state
// - Icache2mem_command   in   2   BUS_NONE=0 / BUS_LOAD=1 (the icache never stores)
// - Icache2mem_addr      in  64   icache line address
// - Dcache2mem_command   in   2   BUS_NONE=0 / BUS_LOAD=1 / BUS_STORE=2
// - Dcache2mem_addr      in  64   dcache address
// - Dcache2mem_data      in  64   store data
// - proc2mem_command     out  2   command to memory
// - proc2mem_addr        out 64   address to memory
// - proc2mem_data        out 64   store data to memory; 0 unless the dcache holds the grant
// - mem2proc_response    in   4   accept tag (0 = rejected)
// - mem2proc_data        in  64   returned load data
// - mem2proc_tag         in   4   tag of the returned data (0 = none)
// - Imem2proc_response   out  4   response to the icache
// - Imem2proc_data       out 64   data to the icache
// - Imem2proc_tag        out  4   tag to the icache
// - Dmem2proc_response   out  4   response to the dcache
// - Dmem2proc_data       out 64   data to the dcache
// - Dmem2proc_tag        out  4   tag to the dcache
// - arb_owner            out  1   0 = icache, 1 = dcache; combinational grant for the current cycle
// - outstanding_cnt      out  5   number of valid owner-table entries (0..16)
// - orphan_err           out  1   sticky: a tag returned with no valid owner entry
// BEHAVIOUR
// - Grant (combinational):
//   - Dcache has priority whenever Dcache2mem_command != 0.
//   - Otherwise the icache is granted.
//   - arb_owner = 0 when both commands are BUS_NONE.
// - Forwarding:
//   - proc2mem_* carry the granted requester's signals.
//   - The granted side receives mem2proc_response; the denied side sees response 0 and must hold and retry.
// - Owner table update (posedge):
//   - On an accepted LOAD (response != 0), entry[response] <= {valid=1, owner=arb_owner}.
//   - Accepted STOREs do not allocate; memory returns no data tag for them.
// - Tag return:
//   - When mem2proc_tag != 0, read entry[mem2proc_tag] combinationally.
//   - If the entry is valid, drive that owner's *_tag/*_data and drive 0/0 to the other side.
//   - At posedge the entry is cleared.
//   - Non-owner data outputs are forced to 0.
// - Same tag returned and re-accepted in one cycle:
//   - Routing uses the old entry.
//   - The new allocation wins at the edge (entry stays valid, with the new owner).
// - Orphan tag (entry invalid):
//   - Both caches see tag 0.
//   - orphan_err <= 1 and stays set until reset.
// - outstanding_cnt is registered:
//   - Allocate only: +1. Free only: -1. Both in the same cycle: unchanged.
//   - Saturates at 16; this is an error condition only reachable with a buggy mem model.
// - Reset (reset==0 at posedge):
//   - Table entries become invalid; outstanding_cnt = 0; orphan_err = 0; starve counter = 0.
//   - Combinational outputs follow the inputs even while reset is held.
//   - Tags returning after a mid-operation reset are orphans and set orphan_err.
// - Latency: 0 cycles through the arbiter in both directions; no buffering.
// CONFIGURATION
// - MEM_ARB_FAIR_EN defined:
//   - A 3-bit starve_cnt increments on each cycle the icache requests and is denied.
//   - It clears on an icache grant.
//   - When starve_cnt == MAX_WAIT and the icache requests, the icache wins that cycle even if the dcache requests.
// - MEM_ARB_FAIR_EN undefined:
//   - Strict dcache priority; starve_cnt is not built.
// TESTING
// - I load only, mem resp=3 -> Imem2proc_response=3, Dmem2proc_response=0; later tag=3 data=0xABCD -> Imem2proc_tag=3 / data 0xABCD, outstanding 1->0.
// - I+D both load, resp=5 -> arb_owner=1, Dmem2proc_response=5, Imem2proc_response=0; tag 5 routes to the dcache only.
// - D store, resp=2 -> proc2mem_data = store data; outstanding_cnt stays 0.
// - Tag 7 returns while 7 is re-accepted for the other cache -> data goes to the old owner; entry valid with the new owner; count unchanged.
// - Tag 9 returns with no entry -> both caches see tag 0; orphan_err=1 and holds until reset==0.
// - FAIR_EN, MAX_WAIT=4: D loads every cycle while I requests -> I granted on the 5th cycle; undefined -> I never granted.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates the shared tagged memory port between icache and dcache and routes returned tags.
// Define MEM_ARB_FAIR_EN to add the icache starvation guard.
module mem_arbiter #(
  parameter int unsigned NUM_TAGS = 16,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  Icache2mem_command,
  input  logic [63:0] Icache2mem_addr,
  input  logic [1:0]  Dcache2mem_command,
  input  logic [63:0] Dcache2mem_addr,
  input  logic [63:0] Dcache2mem_data,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag,
  output logic [3:0]  Imem2proc_response,
  output logic [63:0] Imem2proc_data,
  output logic [3:0]  Imem2proc_tag,
  output logic [3:0]  Dmem2proc_response,
  output logic [63:0] Dmem2proc_data,
  output logic [3:0]  Dmem2proc_tag,
  output logic        arb_owner,
  output logic [4:0]  outstanding_cnt,
  output logic        orphan_err
);

  localparam logic [1:0] BusNone = 2'd0;
  localparam logic [1:0] BusLoad = 2'd1;

  if (MAX_WAIT > 7) begin : gen_max_wait_check
    $error("MAX_WAIT must fit in the 3-bit starve counter");
  end

  logic [NUM_TAGS-1:0] valid_q, valid_d;
  logic [NUM_TAGS-1:0] owner_q, owner_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                orphan_q, orphan_d;
  logic                alloc, ret_valid, ret_owner, ret_orphan;

`ifdef MEM_ARB_FAIR_EN
  logic [2:0] starve_q, starve_d;
`endif

  // Grant: dcache priority, optionally overridden once the icache has waited MAX_WAIT cycles.
  always_comb begin
    arb_owner = (Dcache2mem_command != BusNone);
`ifdef MEM_ARB_FAIR_EN
    if ((starve_q == 3'(MAX_WAIT)) && (Icache2mem_command != BusNone)) begin
      arb_owner = 1'b0;
    end
`endif
  end

  always_comb begin
    proc2mem_command   = arb_owner ? Dcache2mem_command : Icache2mem_command;
    proc2mem_addr      = arb_owner ? Dcache2mem_addr : Icache2mem_addr;
    proc2mem_data      = arb_owner ? Dcache2mem_data : 64'd0;
    Imem2proc_response = arb_owner ? 4'd0 : mem2proc_response;
    Dmem2proc_response = arb_owner ? mem2proc_response : 4'd0;
  end

  // Return routing reads the pre-edge table so a same-cycle re-accept cannot steal the data.
  always_comb begin
    ret_valid  = (mem2proc_tag != 4'd0) && valid_q[mem2proc_tag];
    ret_orphan = (mem2proc_tag != 4'd0) && !valid_q[mem2proc_tag];
    ret_owner  = owner_q[mem2proc_tag];
    Imem2proc_tag  = 4'd0;
    Imem2proc_data = 64'd0;
    Dmem2proc_tag  = 4'd0;
    Dmem2proc_data = 64'd0;
    if (ret_valid && !ret_owner) begin
      Imem2proc_tag  = mem2proc_tag;
      Imem2proc_data = mem2proc_data;
    end
    if (ret_valid && ret_owner) begin
      Dmem2proc_tag  = mem2proc_tag;
      Dmem2proc_data = mem2proc_data;
    end
  end

  always_comb begin
    alloc    = (mem2proc_response != 4'd0) && (proc2mem_command == BusLoad);
    valid_d  = valid_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    orphan_d = orphan_q | ret_orphan;
    if (ret_valid) begin
      valid_d[mem2proc_tag] = 1'b0;
    end
    // Allocation is applied last so it wins over a same-tag free.
    if (alloc) begin
      valid_d[mem2proc_response] = 1'b1;
      owner_d[mem2proc_response] = arb_owner;
    end
    if (alloc && !ret_valid && (cnt_q < 5'(NUM_TAGS))) begin
      cnt_d = cnt_q + 5'd1;
    end else if (!alloc && ret_valid && (cnt_q != 5'd0)) begin
      cnt_d = cnt_q - 5'd1;
    end
  end

`ifdef MEM_ARB_FAIR_EN
  always_comb begin
    starve_d = starve_q;
    if (!arb_owner) begin
      starve_d = 3'd0;
    end else if ((Icache2mem_command != BusNone) && (starve_q != 3'd7)) begin
      starve_d = starve_q + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_q <= 3'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q  <= '0;
      owner_q  <= '0;
      cnt_q    <= 5'd0;
      orphan_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      orphan_q <= orphan_d;
    end
  end

  assign outstanding_cnt = cnt_q;
  assign orphan_err      = orphan_q;

endmodule
